id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter XLEN, 32, datapath width.
REQ-002 Parameter CNTW, 16, stall counter width.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  squash ID instruction (branch/jump resolved taken in EX).
REQ-006 id_valid  input  1  ID holds a real instruction.
REQ-007 id_rs1  input  5  ID source register 1.
REQ-008 id_rs2  input  5  ID source register 2.
REQ-009 id_rd  input  5  ID destination register.
REQ-010 id_ctrl  input  8  bit0 regwrite, bit1 memread, bit2 memwrite, bit3 users1, bit4 users2, bits7:5 ALU select.
REQ-011 id_pc  input  XLEN  ID instruction PC.
REQ-012 id_rs1data  input  XLEN  register-file read data 1.
REQ-013 id_rs2data  input  XLEN  register-file read data 2.
REQ-014 id_imm  input  XLEN  decoded immediate.
REQ-015 ex_valid  output  1  EX holds a real instruction.
REQ-016 ex_rs1  output  5  EX source 1 (feeds forwarding unit).
REQ-017 ex_rs2  output  5  EX source 2 (feeds forwarding unit).
REQ-018 ex_rd  output  5  EX destination.
REQ-019 ex_ctrl  output  8  registered id_ctrl; bits 3/4 drive forwarding users1/users2.
REQ-020 ex_pc, ex_rs1data, ex_rs2data, ex_imm  output  XLEN each  registered ID values.
REQ-021 stall  output  1  combinational load-use hazard; freezes PC and IF/ID.
REQ-022 stall_cnt  output  CNTW  count of inserted load-use bubbles.

Function
REQ-023 Hazard: stall SHALL be 1 iff ex_valid & ex_ctrl[1] & ex_rd!=0 & id_valid & !flush & ((ex_rd==id_rs1 & id_ctrl[3]) | (ex_rd==id_rs2 & id_ctrl[4])).
REQ-024 Bubble: all ex_* outputs SHALL be 0 (valid, ctrl, regs, pc, data, imm).
REQ-025 Each edge, priority SHALL be: RST -> bubble; else flush -> bubble; else stall -> bubble; else capture id_* into ex_* (ex_valid <= id_valid).
REQ-026 id_valid=0 capture SHALL load a bubble regardless of other id_* values.
REQ-027 Latency SHALL be exactly one cycle ID->EX; no other buffering.
REQ-028 A load-use stall SHALL last exactly one cycle: the bubble clears ex_valid, so stall deasserts next cycle and the held ID instruction is captured.
REQ-029 Back-to-back loads with dependent consumers SHALL each cost one bubble; no stall when consumer depends on a non-load or on x0.
REQ-030 Simultaneous flush and hazard: stall SHALL be 0, EX bubbled, stall_cnt unchanged.
REQ-031 stall_cnt SHALL increment by 1 on each edge where stall=1 and RST=0, saturating at all-ones (no wrap).
REQ-032 Dependence test SHALL ignore users bits that are 0 (e.g. id_rs2 of an I-type never causes stall).

Reset
REQ-033 While RST=1 at an edge, ex_* SHALL become bubble and stall_cnt SHALL become 0; stall is then 0 since ex_valid=0. Reset mid-stall discards the pending hazard with no extra bubble afterwards.

Verification
REQ-034 EX=lw x5 (valid, memread, rd=5); ID=add x6,x5,x7 (users1=1, rs1=5) -> stall=1; next edge ex_valid=0, stall_cnt=1; following edge ex_rd=6, ex_rs1=5, stall=0.
REQ-035 EX=lw x5; ID=addi x6,x0,1 with id_rs2=5, users2=0 -> stall=0, captured same edge, stall_cnt=0.
REQ-036 EX=lw x0; ID rs1=0, users1=1 -> stall=0.
REQ-037 EX=lw x5; ID uses x5; flush=1 -> stall=0, next ex_valid=0, stall_cnt unchanged; with flush=0 and ID valid, add x1,x2,x3 captured next edge.
REQ-038 Force stall_cnt to 0xFFFE via 2 hazards past preload (or CNTW=2 build: 4 hazards) -> counter holds all-ones, never wraps to 0.
REQ-039 RST=1 for one edge during stall -> all ex_*=0, stall_cnt=0, stall=0 next cycle.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and a saturating
// count of the bubbles it inserts.
module id_ex_reg #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [7:0]      id_ctrl,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1data,
  input  logic [XLEN-1:0] id_rs2data,
  input  logic [XLEN-1:0] id_imm,
  output logic            ex_valid,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [7:0]      ex_ctrl,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1data,
  output logic [XLEN-1:0] ex_rs2data,
  output logic [XLEN-1:0] ex_imm,
  output logic            stall,
  output logic [CNTW-1:0] stall_cnt
);

  logic ex_is_load;
  logic dep_rs1;
  logic dep_rs2;

  // A flush wins over the hazard: the dependent instruction is squashed anyway.
  always_comb begin
    ex_is_load = ex_valid & ex_ctrl[1] & (ex_rd != 5'd0);
    dep_rs1    = (ex_rd == id_rs1) & id_ctrl[3];
    dep_rs2    = (ex_rd == id_rs2) & id_ctrl[4];
    stall      = ex_is_load & id_valid & ~flush & (dep_rs1 | dep_rs2);
  end

  always_ff @(posedge CLK) begin
    if (RST || flush || stall || !id_valid) begin
      ex_valid   <= 1'b0;
      ex_rs1     <= '0;
      ex_rs2     <= '0;
      ex_rd      <= '0;
      ex_ctrl    <= '0;
      ex_pc      <= '0;
      ex_rs1data <= '0;
      ex_rs2data <= '0;
      ex_imm     <= '0;
    end else begin
      ex_valid   <= 1'b1;
      ex_rs1     <= id_rs1;
      ex_rs2     <= id_rs2;
      ex_rd      <= id_rd;
      ex_ctrl    <= id_ctrl;
      ex_pc      <= id_pc;
      ex_rs1data <= id_rs1data;
      ex_rs2data <= id_rs2data;
      ex_imm     <= id_imm;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Vector-table bench for id_ex_reg; a second narrow-counter instance
// exercises counter saturation on the same stimulus.
module tb_id_ex_reg;

  logic        CLK = 1'b0;
  logic        RST, flush, id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [7:0]  id_ctrl;
  logic [31:0] id_pc, id_rs1data, id_rs2data, id_imm;

  logic        ex_valid, stall;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_pc, ex_rs1data, ex_rs2data, ex_imm;
  logic [15:0] stall_cnt;

  logic        s_valid, s_stall;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [7:0]  s_ctrl;
  logic [31:0] s_pc, s_rs1data, s_rs2data, s_imm;
  logic [1:0]  s_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 CLK = ~CLK;

  id_ex_reg #(.XLEN(32), .CNTW(16)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .id_pc(id_pc), .id_rs1data(id_rs1data), .id_rs2data(id_rs2data), .id_imm(id_imm),
    .ex_valid(ex_valid), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs1data(ex_rs1data),
    .ex_rs2data(ex_rs2data), .ex_imm(ex_imm), .stall(stall), .stall_cnt(stall_cnt)
  );

  id_ex_reg #(.XLEN(32), .CNTW(2)) u_sat (
    .CLK(CLK), .RST(RST), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_ctrl(id_ctrl),
    .id_pc(id_pc), .id_rs1data(id_rs1data), .id_rs2data(id_rs2data), .id_imm(id_imm),
    .ex_valid(s_valid), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
    .ex_ctrl(s_ctrl), .ex_pc(s_pc), .ex_rs1data(s_rs1data),
    .ex_rs2data(s_rs2data), .ex_imm(s_imm), .stall(s_stall), .stall_cnt(s_cnt)
  );

  // ctrl encodings: lw = regwrite|memread|users1, add = regwrite|users1|users2,
  // addi = regwrite|users1, sw = memwrite|users1|users2
  localparam logic [7:0] C_LW   = 8'h0B;
  localparam logic [7:0] C_ADD  = 8'h19;
  localparam logic [7:0] C_ADDI = 8'h09;
  localparam logic [7:0] C_SW   = 8'h1C;

  typedef struct {
    logic       rst, fl, vld;
    logic [4:0] rs1, rs2, rd;
    logic [7:0] ctrl;
    logic       exp_stall, exp_cap;
    logic [15:0] exp_cnt;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic [7:0]  ctrl;
    logic [31:0] pc, d1, d2, imm;
    logic [15:0] cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic rst, fl, vld, input logic [4:0] rs1, rs2, rd,
                              input logic [7:0] ctrl, input logic es, ec,
                              input logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.fl = fl; v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.ctrl = ctrl; v.exp_stall = es; v.exp_cap = ec; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, fl, vld, input logic [4:0] rs1, rs2, rd,
                       input logic [7:0] ctrl, input int unsigned tag);
    RST = rst; flush = fl; id_valid = vld;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_ctrl = ctrl;
    id_pc      = 32'h0000_1000 + tag * 4;
    id_rs1data = 32'hA500_0000 | tag;
    id_rs2data = 32'h5A00_0000 | (tag << 4);
    id_imm     = 32'h0000_0100 + tag * 3;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e, g;
    drive(1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, C_ADD, 99);
    tick;
    tick;
    chk("reset ex_valid", {63'd0, ex_valid}, 64'd0);
    chk("reset ex_rd", {59'd0, ex_rd}, 64'd0);
    chk("reset ex_pc", {32'd0, ex_pc}, 64'd0);
    chk("reset stall_cnt", {48'd0, stall_cnt}, 64'd0);
    chk("reset stall", {63'd0, stall}, 64'd0);

    //            rst  fl   vld  rs1    rs2    rd     ctrl    stall cap  cnt
    tbl.push_back(mk(1'b0,1'b0,1'b1,5'd1, 5'd0, 5'd5, C_LW,  1'b0,1'b1,16'd0)); // lw x5
    tbl.push_back(mk(1'b0,1'b0,1'b1,5'd5, 5'd7, 5'd6, C_ADD, 1'b1,1'b0,16'd1)); // add x6,x5,x7 stalls
    tbl.push_back(mk(1'b0,1'b0,1'b1,5'd5, 5'd7, 5'd6, C_ADD, 1'b0,1'b1,16'd1)); // held add captured
    tbl.push_back(mk(1'b0,1'b0,1'b1,5'd2, 5'd0, 5'd5, C_LW,  1'b0,1'b1,16'd1)); // lw x5 after non-load
    tbl.push_back(mk(1'b0,1'b0,1'b1,5'd0, 5'd5, 5'd6, C_ADDI,1'b0,1'b1,16'd1)); // rs2 ignored, users2=0
    tbl.push_back(mk(1'b0,1'b0,1'b1,5'd3, 5'd0, 5'd0, C_LW,  1'b0,1'b1,16'd1)); // lw x0
    tbl.push_back(mk(1'b0,1'b0,1'b1,5'd0, 5'd4, 5'd7, C_ADD, 1'b0,1'b1,16'd1)); // x0 dependency
    tbl.push_back(mk(1'b0,1'b0,1'b1,5'd1, 5'd0, 5'd5, C_LW,  1'b0,1'b1,16'd1)); // lw x5
    tbl.push_back(mk(1'b0,1'b1,1'b1,5'd5, 5'd7, 5'd6, C_ADD, 1'b0,1'b0,16'd1)); // hazard + flush
    tbl.push_back(mk(1'b0,1'b0,1'b1,5'd2, 5'd3, 5'd1, C_ADD, 1'b0,1'b1,16'd1)); // add x1,x2,x3
    tbl.push_back(mk(1'b0,1'b0,1'b1,5'd1, 5'd0, 5'd8, C_LW,  1'b0,1'b1,16'd1)); // lw x8
    tbl.push_back(mk(1'b0,1'b0,1'b1,5'd8, 5'd0, 5'd9, C_LW,  1'b1,1'b0,16'd2)); // lw x9 <- x8
    tbl.push_back(mk(1'b0,1'b0,1'b1,5'd8, 5'd0, 5'd9, C_LW,  1'b0,1'b1,16'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b1,5'd10,5'd9, 5'd0, C_SW,  1'b1,1'b0,16'd3)); // sw rs2=x9
    tbl.push_back(mk(1'b0,1'b0,1'b1,5'd10,5'd9, 5'd0, C_SW,  1'b0,1'b1,16'd3));
    tbl.push_back(mk(1'b0,1'b0,1'b0,5'd9, 5'd9, 5'd4, C_ADD, 1'b0,1'b0,16'd3)); // id_valid=0
    tbl.push_back(mk(1'b0,1'b0,1'b1,5'd1, 5'd0, 5'd5, C_LW,  1'b0,1'b1,16'd3)); // lw x5
    tbl.push_back(mk(1'b0,1'b0,1'b0,5'd5, 5'd5, 5'd6, C_ADD, 1'b0,1'b0,16'd3)); // invalid consumer
    tbl.push_back(mk(1'b0,1'b0,1'b1,5'd1, 5'd0, 5'd5, C_LW,  1'b0,1'b1,16'd3)); // lw x5
    tbl.push_back(mk(1'b1,1'b0,1'b1,5'd5, 5'd7, 5'd6, C_ADD, 1'b1,1'b0,16'd0)); // reset mid-stall
    tbl.push_back(mk(1'b0,1'b0,1'b1,5'd5, 5'd7, 5'd6, C_ADD, 1'b0,1'b1,16'd0)); // no extra bubble

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].vld, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
            tbl[i].ctrl, i);
      #1;
      chk($sformatf("v%0d stall", i), {63'd0, stall}, {63'd0, tbl[i].exp_stall});
      e.valid = tbl[i].exp_cap;
      e.rs1   = tbl[i].exp_cap ? id_rs1 : 5'd0;
      e.rs2   = tbl[i].exp_cap ? id_rs2 : 5'd0;
      e.rd    = tbl[i].exp_cap ? id_rd : 5'd0;
      e.ctrl  = tbl[i].exp_cap ? id_ctrl : 8'd0;
      e.pc    = tbl[i].exp_cap ? id_pc : 32'd0;
      e.d1    = tbl[i].exp_cap ? id_rs1data : 32'd0;
      e.d2    = tbl[i].exp_cap ? id_rs2data : 32'd0;
      e.imm   = tbl[i].exp_cap ? id_imm : 32'd0;
      e.cnt   = tbl[i].exp_cnt;
      sb.push_back(e);
      tick;
      g = sb.pop_front();
      chk($sformatf("v%0d ex_valid", i), {63'd0, ex_valid}, {63'd0, g.valid});
      chk($sformatf("v%0d ex_rs1", i), {59'd0, ex_rs1}, {59'd0, g.rs1});
      chk($sformatf("v%0d ex_rs2", i), {59'd0, ex_rs2}, {59'd0, g.rs2});
      chk($sformatf("v%0d ex_rd", i), {59'd0, ex_rd}, {59'd0, g.rd});
      chk($sformatf("v%0d ex_ctrl", i), {56'd0, ex_ctrl}, {56'd0, g.ctrl});
      chk($sformatf("v%0d ex_pc", i), {32'd0, ex_pc}, {32'd0, g.pc});
      chk($sformatf("v%0d ex_rs1data", i), {32'd0, ex_rs1data}, {32'd0, g.d1});
      chk($sformatf("v%0d ex_rs2data", i), {32'd0, ex_rs2data}, {32'd0, g.d2});
      chk($sformatf("v%0d ex_imm", i), {32'd0, ex_imm}, {32'd0, g.imm});
      chk($sformatf("v%0d stall_cnt", i), {48'd0, stall_cnt}, {48'd0, g.cnt});
    end

    // Saturation: five load-use hazards; the 2-bit counter must stop at 3.
    for (int k = 1; k <= 5; k++) begin
      drive(1'b0, 1'b0, 1'b1, 5'd1, 5'd0, 5'd5, C_LW, 100 + k);
      tick;
      drive(1'b0, 1'b0, 1'b1, 5'd5, 5'd7, 5'd6, C_ADD, 200 + k);
      #1;
      chk($sformatf("sat%0d stall", k), {63'd0, s_stall}, 64'd1);
      tick;
      chk($sformatf("sat%0d cnt16", k), {48'd0, stall_cnt}, k);
      chk($sformatf("sat%0d cnt2", k), {62'd0, s_cnt}, (k > 3) ? 64'd3 : k);
      tick;
      chk($sformatf("sat%0d resume", k), {63'd0, s_valid}, 64'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
